// File: rtl/fb_pkg.sv
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared widths, FSM state type and the 16-colour palette for the
//            cell framebuffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  localparam int IDX_W = 4;
  localparam int RGB_W = 24;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fb_state_e;

  // EGA-style palette, index 0 is black so a cleared buffer shows nothing.
  localparam logic [RGB_W-1:0] c_palette [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

endpackage

`default_nettype wire

// File: rtl/fb_cell_ram.sv
// ============================================================================
// Module   : fb_cell_ram
// Purpose  : Single-port cell RAM, synchronous read with one cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_cell_ram
  import fb_pkg::*;
#(
  parameter int DEPTH  = 768,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [IDX_W-1:0]  i_wdata,
  output logic [IDX_W-1:0]  o_rdata
);

  logic [IDX_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_arbiter.sv
// ============================================================================
// Module   : fb_arbiter
// Purpose  : Time-slices one cell RAM between video reads (phase 0) and
//            round-robin requester writes (phase 1) after a clear sweep.
//            Optional macro FB_ARB_TEAR_FREE_EN limits grants to the
//            8192-cycle window that starts at each frame_tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_arbiter
  import fb_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 24,
  parameter int NREQ = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [COL_W-1:0]      x,
  input  logic [ROW_W-1:0]      y,
  input  logic                  VGA_VS,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*COL_W-1:0] wcol,
  input  logic [NREQ*ROW_W-1:0] wrow,
  input  logic [NREQ*IDX_W-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  oob,
  output logic                  ready,
  output logic                  frame_tick
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FULL_W = COL_W + ROW_W + 1;
  localparam int PTR_W  = 2;

  fb_state_e         r_state;
  fb_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_phase;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_rd_vld;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_vs_s1;
  logic              r_vs_s2;
  logic              r_vs_prev;
  logic              r_frame_tick;

  logic              w_win;
  logic              w_gnt_any;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_rr_nxt;
  logic              w_grant;
  logic [COL_W-1:0]  w_sel_col;
  logic [ROW_W-1:0]  w_sel_row;
  logic [IDX_W-1:0]  w_sel_data;
  logic [FULL_W-1:0] w_vid_full;
  logic [FULL_W-1:0] w_wr_full;
  logic              w_vid_inr;
  logic              w_wr_inr;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [IDX_W-1:0]  w_ram_wdata;
  logic [IDX_W-1:0]  w_ram_rdata;

  // Addresses stay full width so an out-of-range coordinate can never alias.
  assign w_vid_full = FULL_W'(y) * FULL_W'(COLS) + FULL_W'(x);
  assign w_vid_inr  = (x < COL_W'(COLS)) && (y < ROW_W'(ROWS)) &&
                      (w_vid_full < FULL_W'(DEPTH));

  // Scan from rr_ptr upward; the lowest rotated distance wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && ((int'(r_rr_ptr) + i == j) ||
                       (int'(r_rr_ptr) + i == j + NREQ))) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = PTR_W'(j);
        end
      end
    end
  end

  assign w_rr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_sel_col  = '0;
    w_sel_row  = '0;
    w_sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt_idx == PTR_W'(j)) begin
        w_sel_col  = wcol[j*COL_W +: COL_W];
        w_sel_row  = wrow[j*ROW_W +: ROW_W];
        w_sel_data = wdata[j*IDX_W +: IDX_W];
      end
    end
  end

  assign w_wr_full = FULL_W'(w_sel_row) * FULL_W'(COLS) + FULL_W'(w_sel_col);
  assign w_wr_inr  = (w_sel_col < COL_W'(COLS)) && (w_sel_row < ROW_W'(ROWS)) &&
                     (w_wr_full < FULL_W'(DEPTH));

`ifdef FB_ARB_TEAR_FREE_EN
  localparam int WIN_W = 13;
  logic [WIN_W-1:0] r_win_left;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_win_left <= '0;
    end else if (r_frame_tick) begin
      r_win_left <= '1;
    end else if (r_win_left != '0) begin
      r_win_left <= r_win_left - 1'b1;
    end
  end

  assign w_win = r_frame_tick | (r_win_left != '0);
`else
  assign w_win = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_clr_addr;
    w_ram_wdata = '0;
    w_grant     = 1'b0;
    gnt         = '0;
    oob         = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_ram_en = 1'b1;
        w_ram_we = 1'b1;
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!r_phase) begin
          w_ram_en   = w_vid_inr;
          w_ram_addr = w_vid_full[ADDR_W-1:0];
        end else if (w_win && w_gnt_any) begin
          w_grant     = 1'b1;
          gnt         = NREQ'(1) << w_gnt_idx;
          oob         = ~w_wr_inr;
          w_ram_en    = w_wr_inr;
          w_ram_we    = w_wr_inr;
          w_ram_addr  = w_wr_full[ADDR_W-1:0];
          w_ram_wdata = w_sel_data;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_phase    <= 1'b0;
      r_rr_ptr   <= '0;
      r_rd_vld   <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= (w_state_nxt == ST_RUN) ? '0 : r_clr_addr + 1'b1;
      end
      r_phase  <= (r_state == ST_RUN) ? ~r_phase : 1'b0;
      r_rd_vld <= (r_state == ST_RUN) && !r_phase && w_vid_inr;
      if (w_grant) begin
        r_rr_ptr <= w_rr_nxt;
      end
      // Palette stage loads only after a video read, so each pixel holds 2 cycles.
      if (r_state == ST_CLEAR) begin
        r_rgb <= '0;
      end else if (r_phase) begin
        r_rgb <= r_rd_vld ? c_palette[w_ram_rdata] : '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_s1      <= VGA_VS;
      r_vs_s2      <= r_vs_s1;
      r_vs_prev    <= r_vs_s2;
      r_frame_tick <= r_vs_prev & ~r_vs_s2;
    end
  end

  fb_cell_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLOCK_50),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign r          = r_rgb[23:16];
  assign g          = r_rgb[15:8];
  assign b          = r_rgb[7:0];
  assign ready      = (r_state == ST_RUN);
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
